input_loop_pipe: RTL

Pipelined, clocked successor of the combinational input-channel loop. Each beat multiplies `Tn_p` signed fixed-point feature-map samples by `Tn_p` weights and reduces them through a registered adder tree. The result is accumulated across successive input-channel tiles, seeded from the partial output-fm value on the first tile. The final output value is emitted after the last tile. The block sits between the input/weight buffers and the output-fm buffer, and uses valid/ready handshakes on both sides.

---
 rtl/input_loop_pipe.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/input_loop_pipe.sv
// rtl/input_loop_pipe.sv - pipelined multiply/adder-tree/accumulate input-channel loop with valid/ready handshakes
// Optional INPUT_LOOP_PIPE_SAT_EN: saturate the final narrowing instead of two's-complement wrap.
module input_loop_pipe #(
    parameter int Tn_p         = 4,
    parameter int data_width_p = 16,
    parameter int frac_bits_p  = 8,
    parameter int acc_width_p  = 40
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic                            v_i,
    output logic                            ready_o,
    input  logic [Tn_p*data_width_p-1:0]    fm_i,
    input  logic [Tn_p*data_width_p-1:0]    weights_i,
    input  logic [data_width_p-1:0]         fm_init_i,
    input  logic                            first_i,
    input  logic                            last_i,
    output logic                            v_o,
    input  logic                            ready_i,
    output logic [data_width_p-1:0]         fm_o
);

    localparam int W  = data_width_p;
    localparam int PW = 2 * data_width_p;
    localparam int AW = acc_width_p;

    logic stall;
    logic accept;

    assign stall   = v_o && !ready_i;
    assign ready_o = !stall;
    assign accept  = v_i && ready_o;

    // Stage 1: per-lane full-precision products plus beat sideband
    logic                 s1_v;
    logic                 s1_first;
    logic                 s1_last;
    logic [W-1:0]         s1_init;
    logic signed [PW-1:0] s1_prod [Tn_p];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_v     <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_init  <= '0;
            for (int k = 0; k < Tn_p; k++) begin
                s1_prod[k] <= '0;
            end
        end else if (!stall) begin
            s1_v     <= accept;
            s1_first <= first_i;
            s1_last  <= last_i;
            s1_init  <= fm_init_i;
            for (int k = 0; k < Tn_p; k++) begin
                s1_prod[k] <= $signed(fm_i[k*W +: W]) * $signed(weights_i[k*W +: W]);
            end
        end
    end

    // Stage 2: sign-extended reduction of all lane products
    logic signed [AW-1:0] tree_sum;

    always_comb begin
        tree_sum = '0;
        for (int k = 0; k < Tn_p; k++) begin
            tree_sum = tree_sum + {{(AW-PW){s1_prod[k][PW-1]}}, s1_prod[k]};
        end
    end

    logic                 s2_v;
    logic                 s2_first;
    logic                 s2_last;
    logic [W-1:0]         s2_init;
    logic signed [AW-1:0] s2_sum;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s2_v     <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_init  <= '0;
            s2_sum   <= '0;
        end else if (!stall) begin
            s2_v     <= s1_v;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_init  <= s1_init;
            s2_sum   <= tree_sum;
        end
    end

    // Stage 3: accumulate; products carry 2*frac_bits_p fraction bits, so the seed is pre-shifted
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_seed;
    logic signed [AW-1:0] acc_next;
    logic [W-1:0]         narrow_res;

    assign acc_seed = {{(AW-W){s2_init[W-1]}}, s2_init} <<< frac_bits_p;
    assign acc_next = (s2_first ? acc_seed : acc) + s2_sum;

`ifdef INPUT_LOOP_PIPE_SAT_EN
    localparam logic signed [AW-1:0] sat_max = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] sat_min = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

    logic signed [AW-1:0] acc_shifted;

    assign acc_shifted = acc_next >>> frac_bits_p;

    always_comb begin
        narrow_res = acc_shifted[W-1:0];
        if (acc_shifted > sat_max) begin
            narrow_res = sat_max[W-1:0];
        end else if (acc_shifted < sat_min) begin
            narrow_res = sat_min[W-1:0];
        end
    end
`else
    // Arithmetic shift then wrap reduces to a plain bit slice
    assign narrow_res = acc_next[frac_bits_p +: W];
`endif

    logic         s3_out_v;
    logic [W-1:0] s3_res;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc      <= '0;
            s3_out_v <= 1'b0;
            s3_res   <= '0;
        end else if (!stall) begin
            s3_out_v <= s2_v && s2_last;
            if (s2_v) begin
                acc <= acc_next;
            end
            if (s2_v && s2_last) begin
                s3_res <= narrow_res;
            end
        end
    end

    // Output register: reloads in the same cycle as a transfer for back-to-back results
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_o  <= 1'b0;
            fm_o <= '0;
        end else if (!stall) begin
            v_o <= s3_out_v;
            if (s3_out_v) begin
                fm_o <= s3_res;
            end
        end
    end

endmodule
